stage_b: RTL
============

# stage_B

Second stage of the byte pipeline, directly downstream of stage_A. It accepts bytes from stage_A with the DIR/ack_prev handshake and queues them in a small FIFO. Each byte is doubled (modulo 256) and presented to the next stage with the DOR/ack_from_next handshake. The FIFO decouples upstream acceptance from downstream stalls, so stage_A can keep delivering while the next stage holds off acknowledgement.

## Interface
- `WIDTH`, default 8: data width in bits.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately, independent of `clk`.
- `DIR` input 1: upstream data ready; held high with `data_in` stable until `ack_prev` is seen.
- `data_in` input WIDTH: upstream byte.
- `ack_prev` output 1: one-cycle acceptance pulse to upstream.
- `DOR` output 1: data output ready to the next stage.
- `data_out` output WIDTH: processed byte; stable while `DOR` is high.
- `ack_from_next` input 1: downstream acknowledge.
- `count` output $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH. Excludes the byte held in the output register.

## Operation
- Reset values: `ack_prev`=0, `DOR`=0, `data_out`=0, `count`=0. Both FSMs return to their idle states and the FIFO pointers go to 0.
- Reset mid-operation discards any queued or presented byte. There is no ack for a partially accepted transfer.

Intake FSM:
- States are I_IDLE and I_HOLD.
- I_IDLE, with `DIR`=1 and `count`<DEPTH: push `data_in` into the FIFO, set `ack_prev`<=1, go to I_HOLD.
- I_IDLE, with `DIR`=1 and `count`==DEPTH: no push, `ack_prev` stays 0, stay in I_IDLE. Upstream stalls.
- I_HOLD: `ack_prev`<=0, `DIR` is ignored, and the FSM returns to I_IDLE. This is required because upstream drops DIR one cycle after it sees the ack, so without I_HOLD the same byte would be accepted twice.

Output FSM:
- States are O_IDLE and O_WAIT.
- O_IDLE, with `count`>0: pop the head into `data_out` <= (head × 2) mod 2^WIDTH, i.e. `{head[WIDTH-2:0],1'b0}`. Set `DOR`<=1 and go to O_WAIT.
- O_WAIT, with `ack_from_next`=1: `DOR`<=0, go to O_IDLE. `data_out` holds its last value.
- O_WAIT, with `ack_from_next`=0: stay in O_WAIT. `DOR` and `data_out` are unchanged.
- In O_IDLE, `ack_from_next` is ignored.

FIFO rules:
- Read and write pointers wrap modulo DEPTH.
- A push and a pop on the same edge leave `count` unchanged. A push while full and a pop while empty never occur.

## Timing
- Accept: `DIR` is sampled high at edge N in I_IDLE and not full. `ack_prev` is high for exactly cycle N→N+1. `count` increments after edge N, unless a pop occurs on the same edge.
- Fall-through latency: a byte accepted at edge N into an empty FIFO with the output FSM in O_IDLE gives `DOR`=1 after edge N+1.
- Intake throughput: at most one byte per 2 cycles.
- Output: `ack_from_next` sampled high at edge M gives `DOR`=0 after M. A next byte, if queued, gives `DOR`=1 after M+1. `DOR` is therefore low for exactly one cycle between back-to-back bytes.
- Full boundary: with `count`==DEPTH and a pop at edge K, the first `DIR` acceptance is at edge K+1.

## Test plan
- Reset: drive `reset`=0 asynchronously mid-cycle with `DOR`=1 and `count`=2 → all outputs 0 before the next edge. After release, a `DIR` with 8'h05 gives `data_out`=8'h0A.
- Single transfer: `DIR`=1 with 8'h21 at edge 0 and `ack_from_next` tied high → `ack_prev` pulses one cycle, `DOR`=1 after edge 1 with `data_out`=8'h42, `DOR`=0 after edge 2. Exactly one byte is delivered even though `DIR` is held through edge 1.
- Wrap and overflow: input 8'h80 → 8'h00; input 8'hFF → 8'hFE.
- Fill: `ack_from_next`=0, send 8'h01..8'h06 → bytes 1–5 accepted (1 in the output register, `count`=4). Byte 6 gets no `ack_prev` until one ack occurs, and is accepted one edge after that pop.
- Drain order: after fill, pulse `ack_from_next` whenever `DOR`=1 → `data_out` sequence 02,04,06,08,0A,0C, with `DOR` low exactly one cycle between items.
- Simultaneous events: a push and a pop on the same edge at `count`=2 → `count` stays 2, and data order is preserved across pointer wrap (≥ 2×DEPTH bytes streamed).

Source files
------------

// File: rtl/stage_b.sv
// stage_b: second stage of the byte pipeline.
// Takes bytes from upstream over the DIR/ack_prev handshake and queues them
// in a small FIFO. Each byte leaves doubled (mod 2^WIDTH) over the
// DOR/ack_from_next handshake. The FIFO lets upstream keep delivering while
// the next stage is slow to acknowledge.
`timescale 1ns/1ps

module stage_b #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     DIR,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ack_prev,
    output logic                     DOR,
    output logic [WIDTH-1:0]         data_out,
    input  logic                     ack_from_next,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {
        I_IDLE = 1'b0,
        I_HOLD = 1'b1
    } istate_t;

    typedef enum logic {
        O_IDLE = 1'b0,
        O_WAIT = 1'b1
    } ostate_t;

    istate_t           istate_r;
    ostate_t           ostate_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              ack_prev_r;
    logic              dor_r;
    logic [WIDTH-1:0]  data_out_r;
    logic              push_s;
    logic              pop_s;

    // Doubling modulo 2^WIDTH is a left shift that drops the MSB.
    function automatic logic [WIDTH-1:0] double_val(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    assign ack_prev = ack_prev_r;
    assign DOR      = dor_r;
    assign data_out = data_out_r;
    assign count    = count_r;

    // Push/pop decisions from the registered FSM states and occupancy.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if ((istate_r == I_IDLE) && DIR && (count_r != CNT_FULL)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if ((ostate_r == O_IDLE) && (count_r != CNT_ZERO)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Intake FSM: accept one byte, then hold one cycle so a DIR still high
    // from the same transfer is not taken twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            istate_r   <= I_IDLE;
            ack_prev_r <= 1'b0;
        end else begin
            case (istate_r)
                I_IDLE: begin
                    if (push_s) begin
                        ack_prev_r <= 1'b1;
                        istate_r   <= I_HOLD;
                    end else begin
                        ack_prev_r <= 1'b0;
                        istate_r   <= I_IDLE;
                    end
                end
                I_HOLD: begin
                    ack_prev_r <= 1'b0;
                    istate_r   <= I_IDLE;
                end
                default: begin
                    ack_prev_r <= 1'b0;
                    istate_r   <= I_IDLE;
                end
            endcase
        end
    end

    // FIFO storage, wrapping pointers and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data_in;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Output FSM: load the doubled head into the output register and hold
    // it with DOR high until the next stage acknowledges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ostate_r   <= O_IDLE;
            dor_r      <= 1'b0;
            data_out_r <= '0;
        end else begin
            case (ostate_r)
                O_IDLE: begin
                    if (pop_s) begin
                        data_out_r <= double_val(mem_r[rd_ptr_r]);
                        dor_r      <= 1'b1;
                        ostate_r   <= O_WAIT;
                    end else begin
                        dor_r      <= 1'b0;
                        ostate_r   <= O_IDLE;
                    end
                end
                O_WAIT: begin
                    if (ack_from_next) begin
                        dor_r    <= 1'b0;
                        ostate_r <= O_IDLE;
                    end else begin
                        dor_r    <= 1'b1;
                        ostate_r <= O_WAIT;
                    end
                end
                default: begin
                    dor_r    <= 1'b0;
                    ostate_r <= O_IDLE;
                end
            endcase
        end
    end

endmodule
